// File: rtl/pipe_ctl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states, shadow entry.
// No logic of its own; no latency or backpressure.
// Field widths match the MIPS 32-entry register file.
package pipe_ctl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } ctlState_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dst;
        logic             regwrite;
        logic             load;
    } shEntry_t;

endpackage

// File: rtl/pipe_ctl_hazard_cmp.sv
// Matches one source register against one in-flight shadow entry.
// Purely combinational; no backpressure.
// r0 writes never match since r0 is hard-wired to zero.
module hazard_cmp
    import pipe_ctl_pkg::*;
(
    input  shEntry_t         entry,
    input  logic [REG_W-1:0] src,
    input  logic             srcUsed,
    output logic             match
);

    assign match = entry.valid & entry.regwrite & (entry.dst != '0)
                 & srcUsed & (entry.dst == src);

endmodule

// File: rtl/pipe_ctl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipe; PIPE_CTL_FWD_EN enables EX forwarding.
// Stall/flush/forward outputs are combinational (same cycle); shadow state, FSM, counter on clk.
// Multi-cycle EX holds IF/ID/EX and bubbles MEM; load-use (or any RAW without forwarding) holds IF/ID.
module pipe_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic [REG_W-1:0]       id_dst,
    input  logic                   id_regwrite,
    input  logic                   id_load,
    input  logic                   id_jump,
    input  logic                   ex_mc_start,
    input  logic                   ex_mc_done,
    input  logic                   ex_branch_taken,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   stall_ex,
    output logic                   bubble_ex,
    output logic                   flush_if,
    output logic                   flush_id,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    ctlState_t state, stateNext;
    shEntry_t  exEnt, memEnt, wbEnt, idEnt;
    shEntry_t  stEnt [3];
    logic [2:0] idMatchRs, idMatchRt;
    logic       dataHaz, mcHold, brTaken, inBusy;
    logic       unusedBits;

    // Unused sources are recorded as r0 so they can never produce a match later.
    always_comb begin
        idEnt          = '0;
        idEnt.valid    = id_valid;
        idEnt.rs       = id_use_rs ? id_rs : '0;
        idEnt.rt       = id_use_rt ? id_rt : '0;
        idEnt.dst      = id_dst;
        idEnt.regwrite = id_regwrite;
        idEnt.load     = id_load;
    end

    assign stEnt[0] = exEnt;
    assign stEnt[1] = memEnt;
    assign stEnt[2] = wbEnt;

    for (genvar s = 0; s < 3; s++) begin : gIdCmp
        hazard_cmp uRs (.entry(stEnt[s]), .src(id_rs), .srcUsed(id_use_rs), .match(idMatchRs[s]));
        hazard_cmp uRt (.entry(stEnt[s]), .src(id_rt), .srcUsed(id_use_rt), .match(idMatchRt[s]));
    end

`ifdef PIPE_CTL_FWD_EN
    logic aMem, aWb, bMem, bWb;

    hazard_cmp uAMem (.entry(memEnt), .src(exEnt.rs), .srcUsed(exEnt.valid), .match(aMem));
    hazard_cmp uAWb  (.entry(wbEnt),  .src(exEnt.rs), .srcUsed(exEnt.valid), .match(aWb));
    hazard_cmp uBMem (.entry(memEnt), .src(exEnt.rt), .srcUsed(exEnt.valid), .match(bMem));
    hazard_cmp uBWb  (.entry(wbEnt),  .src(exEnt.rt), .srcUsed(exEnt.valid), .match(bWb));

    assign fwd_a   = aMem ? FWD_MEM : (aWb ? FWD_WB : FWD_RF);
    assign fwd_b   = bMem ? FWD_MEM : (bWb ? FWD_WB : FWD_RF);
    assign dataHaz = id_valid & exEnt.load & (idMatchRs[0] | idMatchRt[0]);
`else
    // No bypass and no register-file write-through: wait until the writer has retired.
    assign fwd_a   = FWD_RF;
    assign fwd_b   = FWD_RF;
    assign dataHaz = id_valid & ((|idMatchRs) | (|idMatchRt));
`endif

    assign unusedBits = ^{exEnt.rs, exEnt.rt, memEnt.rs, memEnt.rt, memEnt.load,
                          wbEnt.rs, wbEnt.rt, wbEnt.load};

    assign inBusy  = (state == ST_BUSY);
    assign mcHold  = (((state == ST_RUN) & ex_mc_start) | inBusy) & ~ex_mc_done;
    assign brTaken = ex_branch_taken & ~inBusy;

    always_comb begin
        stateNext = state;
        case (state)
            ST_RUN:  if (ex_mc_start && !ex_mc_done) stateNext = ST_BUSY;
            ST_BUSY: if (ex_mc_done) stateNext = ST_RUN;
            default: stateNext = ST_RUN;
        endcase
    end

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        flush_if  = 1'b0;
        if (mcHold) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
        end else if (brTaken) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (dataHaz) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
        // A jump squashed by a taken branch must not redirect fetch.
        flush_if = id_valid & id_jump & ~stall_id & ~flush_id;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_RUN;
            exEnt  <= '0;
            memEnt <= '0;
            wbEnt  <= '0;
        end else begin
            state <= stateNext;
            if (stall_ex) begin
                memEnt <= '0;
                wbEnt  <= memEnt;
            end else begin
                exEnt  <= (bubble_ex || flush_id || !id_valid) ? '0 : idEnt;
                memEnt <= exEnt;
                wbEnt  <= memEnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_id && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl; expectations adapt to whether PIPE_CTL_FWD_EN is defined.
module tb_pipe_ctl;
    import pipe_ctl_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

`ifdef PIPE_CTL_FWD_EN
    localparam int         RAW_ST = 0;
    localparam int         LU_ST  = 1;
    localparam logic [1:0] RAW_FA = FWD_MEM;
    localparam logic [1:0] LU_FA  = FWD_WB;
`else
    localparam int         RAW_ST = 3;
    localparam int         LU_ST  = 3;
    localparam logic [1:0] RAW_FA = FWD_RF;
    localparam logic [1:0] LU_FA  = FWD_RF;
`endif

    // {stall_if, stall_id, stall_ex, bubble_ex, flush_if, flush_id}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_MC   = 6'b111000;
    localparam logic [5:0] C_BR   = 6'b000101;
    localparam logic [5:0] C_JMP  = 6'b000010;

    logic clk, reset;
    logic id_valid, id_use_rs, id_use_rt, id_regwrite, id_load, id_jump;
    logic [4:0] id_rs, id_rt, id_dst;
    logic ex_mc_start, ex_mc_done, ex_branch_taken;
    logic stall_if, stall_id, stall_ex, bubble_ex, flush_if, flush_id;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cycles;
    logic [5:0] ctl;

    int total = 0;
    int bad   = 0;
    int expCnt = 0;

    pipe_ctl #(.STALL_CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_load(id_load), .id_jump(id_jump),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .ex_branch_taken(ex_branch_taken),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .bubble_ex(bubble_ex), .flush_if(flush_if), .flush_id(flush_id),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
    );

    assign ctl = {stall_if, stall_id, stall_ex, bubble_ex, flush_if, flush_id};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are applied at the falling edge; outputs are checked 2ns later.
    task automatic step(input string tag, input logic [5:0] expCtl,
                        input logic [1:0] expFa, input logic [1:0] expFb);
        #2;
        chk({tag, ".ctl"}, 32'(ctl), 32'(expCtl));
        chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(expFa));
        chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(expFb));
        chk({tag, ".cnt"}, 32'(stall_cycles), 32'(expCnt));
        if (expCtl[4]) expCnt = (expCnt == CNT_MAX) ? CNT_MAX : expCnt + 1;
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_dst = 0; id_regwrite = 0; id_load = 0; id_jump = 0;
        ex_mc_start = 0; ex_mc_done = 0; ex_branch_taken = 0;
    endtask

    task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dst,
                         input logic rw, input logic ld, input logic jmp);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_dst = dst; id_regwrite = rw; id_load = ld; id_jump = jmp;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) step("drain", C_NONE, FWD_RF, FWD_RF);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        step("reset", C_NONE, FWD_RF, FWD_RF);
        reset = 1'b0;

        // independent instructions
        setId(1, 1, 2, 1, 1, 3, 1, 0, 0);  step("nodep0", C_NONE, FWD_RF, FWD_RF);
        setId(1, 4, 5, 1, 1, 6, 1, 0, 0);  step("nodep1", C_NONE, FWD_RF, FWD_RF);
        drain(3);

        // ALU writer r5, then reader of r5
        setId(1, 0, 0, 0, 0, 5, 1, 0, 0);  step("raw_wr", C_NONE, FWD_RF, FWD_RF);
        setId(1, 5, 0, 1, 0, 7, 1, 0, 0);
        repeat (RAW_ST) step("raw_stall", C_LU, FWD_RF, FWD_RF);
        step("raw_go", C_NONE, FWD_RF, FWD_RF);
        idle();                            step("raw_ex", C_NONE, RAW_FA, FWD_RF);
        drain(3);

        // load r8, then reader of r8
        setId(1, 0, 0, 0, 0, 8, 1, 1, 0);  step("lu_ld", C_NONE, FWD_RF, FWD_RF);
        setId(1, 8, 9, 1, 1, 10, 1, 0, 0);
        repeat (LU_ST) step("lu_stall", C_LU, FWD_RF, FWD_RF);
        step("lu_go", C_NONE, FWD_RF, FWD_RF);
        idle();                            step("lu_ex", C_NONE, LU_FA, FWD_RF);
        drain(3);

        // matching register but source unused; r0 writer never a hazard
        setId(1, 0, 0, 0, 0, 11, 1, 1, 0); step("unused_ld", C_NONE, FWD_RF, FWD_RF);
        setId(1, 11, 11, 0, 0, 12, 1, 0, 0); step("unused_rd", C_NONE, FWD_RF, FWD_RF);
        drain(3);
        setId(1, 0, 0, 0, 0, 0, 1, 1, 0);  step("r0_ld", C_NONE, FWD_RF, FWD_RF);
        setId(1, 0, 0, 1, 1, 13, 1, 0, 0); step("r0_rd", C_NONE, FWD_RF, FWD_RF);
        drain(3);

`ifdef PIPE_CTL_FWD_EN
        setId(1, 0, 0, 0, 0, 3, 1, 0, 0);  step("f_add", C_NONE, FWD_RF, FWD_RF);
        setId(1, 1, 3, 1, 1, 15, 1, 0, 0); step("f_sub", C_NONE, FWD_RF, FWD_RF);
        setId(1, 3, 2, 1, 0, 16, 1, 0, 0); step("f_or", C_NONE, FWD_RF, FWD_MEM);
        idle();                            step("f_or_ex", C_NONE, FWD_WB, FWD_RF);
        drain(3);
        setId(1, 0, 0, 0, 0, 4, 1, 0, 0);  step("f_w1", C_NONE, FWD_RF, FWD_RF);
        setId(1, 0, 0, 0, 0, 4, 1, 0, 0);  step("f_w2", C_NONE, FWD_RF, FWD_RF);
        setId(1, 4, 4, 1, 1, 17, 1, 0, 0); step("f_rd", C_NONE, FWD_RF, FWD_RF);
        idle();                            step("f_memwin", C_NONE, FWD_MEM, FWD_MEM);
        drain(3);
        setId(1, 0, 0, 0, 0, 0, 1, 0, 0);  step("f_r0w", C_NONE, FWD_RF, FWD_RF);
        setId(1, 0, 0, 1, 1, 18, 1, 0, 0); step("f_r0r", C_NONE, FWD_RF, FWD_RF);
        idle();                            step("f_r0ex", C_NONE, FWD_RF, FWD_RF);
        drain(3);
`endif

        // taken branch beats a load-use; flushed ID must not enter EX
        setId(1, 0, 0, 0, 0, 8, 1, 1, 0);  step("br_ld", C_NONE, FWD_RF, FWD_RF);
        setId(1, 8, 0, 1, 0, 14, 1, 1, 0);
        ex_branch_taken = 1;               step("br_taken", C_BR, FWD_RF, FWD_RF);
        ex_branch_taken = 0;
        setId(1, 14, 0, 1, 0, 19, 1, 0, 0); step("br_after", C_NONE, FWD_RF, FWD_RF);
        drain(3);

        // jr r10 behind a load of r10: redirect only once ID advances
        setId(1, 0, 0, 0, 0, 10, 1, 1, 0); step("jr_ld", C_NONE, FWD_RF, FWD_RF);
        setId(1, 10, 0, 1, 0, 0, 0, 0, 1);
        repeat (LU_ST) step("jr_stall", C_LU, FWD_RF, FWD_RF);
        step("jr_go", C_JMP, FWD_RF, FWD_RF);
        idle();                            step("jr_ex", C_NONE, LU_FA, FWD_RF);
        drain(3);

        // four-cycle EX op: three hold cycles; branch ignored while busy
        setId(1, 1, 2, 1, 1, 9, 1, 0, 0);
        ex_mc_start = 1;                   step("mc10", C_MC, FWD_RF, FWD_RF);
        ex_mc_start = 0; ex_branch_taken = 1; step("mc11", C_MC, FWD_RF, FWD_RF);
        ex_branch_taken = 0;               step("mc12", C_MC, FWD_RF, FWD_RF);
        ex_mc_done = 1;                    step("mc13", C_NONE, FWD_RF, FWD_RF);
        idle();
        ex_mc_start = 1; ex_mc_done = 1;   step("mc20", C_NONE, FWD_RF, FWD_RF);
        idle();                            step("mc21", C_NONE, FWD_RF, FWD_RF);
        drain(2);

        // reset while busy
        ex_mc_start = 1;                   step("rb_start", C_MC, FWD_RF, FWD_RF);
        ex_mc_start = 0;                   step("rb_busy", C_MC, FWD_RF, FWD_RF);
        reset = 1; expCnt = 0;             step("rb_reset", C_NONE, FWD_RF, FWD_RF);
        reset = 0;                         step("rb_after", C_NONE, FWD_RF, FWD_RF);

        // 17 hold cycles: counter saturates
        ex_mc_start = 1;                   step("sat_start", C_MC, FWD_RF, FWD_RF);
        ex_mc_start = 0;
        repeat (16) step("sat_busy", C_MC, FWD_RF, FWD_RF);
        ex_mc_done = 1;                    step("sat_done", C_NONE, FWD_RF, FWD_RF);
        idle();                            step("sat_hold", C_NONE, FWD_RF, FWD_RF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
